// File: rtl/shift_sequencer.sv
// Multi-cycle SLL/SRL/SRA shift controller: 2-bit steps plus a final 1-bit step for odd amounts.
// Define SHIFT_SEQ_ROTR_EN to decode op 2'b10 as rotate-right; otherwise it behaves as SLL.
module shift_sequencer #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic [1:0]             i_op,
  input  logic [DATA_WIDTH-1:0]  i_data,
  input  logic [SHAMT_WIDTH-1:0] i_shamt,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [DATA_WIDTH-1:0]  o_data
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SHIFT2 = 2'd1;
  localparam logic [1:0] S_SHIFT1 = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam int CW = SHAMT_WIDTH - 1;
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  function automatic logic [DATA_WIDTH-1:0] step2(input logic [1:0] op,
                                                  input logic [DATA_WIDTH-1:0] v);
    logic [DATA_WIDTH-1:0] r;
    case (op)
      2'b01:   r = {2'b00, v[DATA_WIDTH-1:2]};
      2'b11:   r = {{2{v[DATA_WIDTH-1]}}, v[DATA_WIDTH-1:2]};
`ifdef SHIFT_SEQ_ROTR_EN
      2'b10:   r = {v[1:0], v[DATA_WIDTH-1:2]};
`endif
      default: r = {v[DATA_WIDTH-3:0], 2'b00};
    endcase
    return r;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] step1(input logic [1:0] op,
                                                  input logic [DATA_WIDTH-1:0] v);
    logic [DATA_WIDTH-1:0] r;
    case (op)
      2'b01:   r = {1'b0, v[DATA_WIDTH-1:1]};
      2'b11:   r = {v[DATA_WIDTH-1], v[DATA_WIDTH-1:1]};
`ifdef SHIFT_SEQ_ROTR_EN
      2'b10:   r = {v[0], v[DATA_WIDTH-1:1]};
`endif
      default: r = {v[DATA_WIDTH-2:0], 1'b0};
    endcase
    return r;
  endfunction

  logic [1:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] work_q, work_d;
  logic [1:0]            op_q, op_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  odd_q, odd_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  done_q, done_d;
  logic [1:0]            capture_next;

  assign capture_next = (i_shamt[SHAMT_WIDTH-1:1] != '0) ? S_SHIFT2 :
                        (i_shamt[0] ? S_SHIFT1 : S_DONE);

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
    state_d = state_q;
    work_d  = work_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    odd_d   = odd_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          work_d  = i_data;
          op_d    = i_op;
          cnt_d   = i_shamt[SHAMT_WIDTH-1:1];
          odd_d   = i_shamt[0];
          state_d = capture_next;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT2: begin
        work_d = step2(op_q, work_q);
        cnt_d  = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) state_d = odd_q ? S_SHIFT1 : S_DONE;
      end
      S_SHIFT1: begin
        work_d  = step1(op_q, work_q);
        state_d = S_DONE;
      end
    endcase
    // The result register is loaded only when entering DONE, so it holds across later operations.
    data_d = (state_d == S_DONE) ? work_d : data_q;
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (i_rst) begin
      state_q <= S_IDLE;
      work_q  <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      odd_q   <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      odd_q   <= odd_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  assign o_busy = (state_q != S_IDLE);
  assign o_done = done_q;
  assign o_data = data_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: driver pushes model results with their due cycle, monitor pops on o_done.
module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] data = 32'd0;
  logic [4:0]  shamt = 5'd0;
  logic        busy, done;
  logic [31:0] dout;

  shift_sequencer #(.DATA_WIDTH(32), .SHAMT_WIDTH(5)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_start(start),
    .i_op   (op),
    .i_data (data),
    .i_shamt(shamt),
    .o_busy (busy),
    .o_done (done),
    .o_data (dout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  bit          busy_map[int];
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  bit          mon_en = 1'b0;
  bit          rst_was = 1'b1;
  logic [31:0] last_data = 32'd0;
  int          cur_n = 0;
  int          cur_done = 0;

  always @(posedge clk) begin
    cyc++;
    rst_was = rst;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h want %h", name, cyc, act, exp);
    end
  endtask

  // Reference: whole-amount shifts computed directly from the op semantics.
  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] d, input int s);
    logic signed [31:0] sd;
    sd = d;
    case (o)
      2'd1: return d >> s;
      2'd3: return 32'(sd >>> s);
`ifdef SHIFT_SEQ_ROTR_EN
      2'd2: return (s == 0) ? d : ((d >> s) | (d << (32 - s)));
`endif
      default: return d << s;
    endcase
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      if (rst_was) last_data = 32'd0;
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        total++;
        bad++;
        $display("FAIL missing_done: got no o_done, want one at cycle %0d", sb[0].cyc);
        void'(sb.pop_front());
      end
      if (done) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_done at cycle %0d: got o_done=1 want 0", cyc);
        end else begin
          mon_e = sb.pop_front();
          check("done_cycle", cyc, mon_e.cyc);
          check("done_data", dout, mon_e.data);
          last_data = mon_e.data;
        end
      end
      check("busy", {31'd0, busy}, {31'd0, busy_map.exists(cyc)});
      check("hold_data", dout, last_data);
    end
  end

  task automatic randomize_inputs();
    op    = 2'($urandom);
    data  = $urandom;
    shamt = 5'($urandom);
  endtask

  // Called at a negedge while the DUT is in IDLE or DONE.
  task automatic issue(input logic [1:0] o, input logic [31:0] d, input int s);
    op    = o;
    data  = d;
    shamt = s[4:0];
    start = 1'b1;
    cur_n    = cyc;
    cur_done = cyc + 1 + s / 2 + s % 2;
    sb.push_back('{model(o, d, s), cur_done});
    for (int c = cur_n + 1; c <= cur_done; c++) busy_map[c] = 1'b1;
    @(negedge clk);
    start = 1'b0;
    randomize_inputs();
  endtask

  // Advance to the DONE cycle, optionally pulsing i_start during shift cycles.
  task automatic run_to_done(input bit junk);
    while (cyc < cur_done) begin
      start = junk && ($urandom_range(0, 3) == 0);
      if (start) randomize_inputs();
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_data", dout, 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;

    issue(2'd0, 32'h0000_0001, 2);
    run_to_done(1'b0);
    idle(1);
    issue(2'd3, 32'h8000_0000, 31);
    run_to_done(1'b1);
    idle(2);
    issue(2'd1, 32'h8000_0000, 31);
    run_to_done(1'b0);
    idle(1);
    issue(2'd1, 32'hDEAD_BEEF, 0);
    run_to_done(1'b0);
    idle(1);

    // Back-to-back with an ignored start pulse while shifting.
    issue(2'd0, 32'h0000_0003, 3);
    start = 1'b1;
    op    = 2'd0;
    data  = 32'hFFFF_FFFF;
    shamt = 5'd5;
    @(negedge clk);
    start = 1'b0;
    run_to_done(1'b0);
    issue(2'd1, 32'h0000_0100, 4);
    run_to_done(1'b0);
    idle(2);

    issue(2'd2, 32'h0000_0001, 1);
    run_to_done(1'b0);
    idle(1);

    // Reset mid-operation discards the request.
    issue(2'd3, 32'hF0F0_1234, 20);
    while (cyc < cur_n + 5) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    for (int c = cyc + 1; c <= cur_done; c++) busy_map.delete(c);
    @(negedge clk);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_data", dout, 32'd0);
    rst = 1'b0;
    idle(25);

    repeat (150) begin
      issue(2'($urandom), $urandom, int'($urandom_range(0, 31)));
      run_to_done(1'($urandom));
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
    end
    idle(3);
    check("drain", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-cycle shift unit controller for the MIPS32 execute stage. It implements SLL/SRL/SRA (and optionally ROTR) by issuing a 2-bit shift step on most cycles, plus one final 1-bit step when the shift amount is odd. This keeps a full 32-bit barrel shifter out of the datapath. The block accepts one shift request at a time and returns a registered result with a one-cycle done pulse that the pipeline stall logic consumes.

## Interface
Parameters:
- DATA_WIDTH, 32, operand/result width
- SHAMT_WIDTH, 5, shift-amount width

Ports:
- i_clk  input  1  clock, rising edge
- i_rst  input  1  synchronous, active-high reset
- i_start  input  1  request strobe; sampled only in IDLE or DONE
- i_op  input  2  00 SLL, 01 SRL, 11 SRA, 10 ROTR (see Configuration)
- i_data  input  DATA_WIDTH  operand
- i_shamt  input  SHAMT_WIDTH  shift amount, 0..31
- o_busy  output  1  high in every state except IDLE
- o_done  output  1  one-cycle pulse; the result is valid on o_data
- o_data  output  DATA_WIDTH  last completed result, registered

## Operation
- Reset values: state IDLE, o_busy 0, o_done 0, o_data 0. The internal working register, count and odd flag are all 0.
- States: IDLE, SHIFT2, SHIFT1, DONE.
- Capture: i_start is sampled in IDLE or DONE. On capture, the block latches:
  - work ← i_data
  - op ← i_op
  - cnt ← i_shamt[SHAMT_WIDTH-1:1]
  - odd ← i_shamt[0]
- Next state after capture: SHIFT2 if cnt≠0, else SHIFT1 if odd, else DONE.
- SHIFT2: performs one 2-bit step on work and decrements cnt.
  - When cnt==1 is consumed, the next state is SHIFT1 if odd, else DONE.
- SHIFT1: performs one 1-bit step, then goes to DONE.
- Step rules by op:
  - SLL: zero-fill from the LSB side.
  - SRL: zero-fill from the MSB side.
  - SRA: replicate work[DATA_WIDTH-1] into the vacated MSBs on every step.
- DONE:
  - o_data ← work is written on entry to DONE, so it is valid throughout DONE.
  - o_done is high for exactly that cycle.
  - Without i_start, the next state is IDLE.
  - With i_start, the block captures a new request and goes directly to SHIFT2/SHIFT1/DONE, giving back-to-back operation.
- i_start in SHIFT2/SHIFT1 is ignored; the request is not queued.
- o_data holds its value from one DONE to the next. It is not disturbed while a later operation is in progress.
- i_op/i_data/i_shamt are don't-care except in the capture cycle.

## Timing
- Let start be captured at cycle N.
- Shift cycles: K = floor(shamt/2) + shamt[0].
- DONE, with o_done=1, occurs in cycle N+1+K:
  - shamt=0 → N+1
  - shamt=1 → N+2
  - shamt=2 → N+2
  - shamt=31 → N+17
- o_busy rises at N+1 and falls after DONE, unless a new request is captured in DONE.
- Reset asserted in any state: on the next edge the block is in IDLE with all outputs 0. The in-flight operation is discarded and o_done does not fire.
- Reset takes priority over i_start in the same cycle.

## Configuration
- Macro SHIFT_SEQ_ROTR_EN.
- Defined: op 10 is ROTR. Each step rotates right, with the bits leaving the LSB re-entering at the MSB. Latency is identical to the other ops.
- Undefined: op 10 decodes as SLL, and no rotate logic is synthesized.

## Test plan
- SLL, i_data=0x00000001, shamt=2 → o_done at N+2, o_data=0x00000004.
- SRA, i_data=0x80000000, shamt=31 → o_busy high N+1..N+17, o_done at N+17, o_data=0xFFFFFFFF. SRL with the same operands → 0x00000001.
- shamt=0, SRL, i_data=0xDEADBEEF → o_done at N+1, o_data=0xDEADBEEF.
- Back-to-back: issue SLL 0x3 by 3 (result 0x18), then hold i_start in DONE with SRL 0x100 by 4 → second o_done 3 cycles later, o_data=0x10. A pulse of i_start in SHIFT2 is ignored, so only two o_done pulses occur.
- Reset mid-op: start SRA shamt=20, assert i_rst at N+5 → next cycle o_busy=0, o_done=0, o_data=0, and no done pulse follows.
- op=10, i_data=0x00000001, shamt=1:
  - with SHIFT_SEQ_ROTR_EN → 0x80000000
  - without → 0x00000002
